// File: rtl/sub_int32_serial.sv
// sub_int32_serial: bit-serial two's complement subtractor, result = a + ~b + 1, DIGIT bits per cycle, LSB first
// Ports: clk, rst (async, active-high)
//        in_valid/in_ready with operands a (minuend), b (subtrahend)
//        out_valid/out_ready with result (a - b mod 2^WIDTH), borrow_out (unsigned a < b)
// Define SUB_INT32_SERIAL_FLAGS_EN to add overflow (signed) and zero outputs, valid with out_valid.
module sub_int32_serial #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             borrow_out
`ifdef SUB_INT32_SERIAL_FLAGS_EN
  ,
  output logic             overflow,
  output logic             zero
`endif
);
  localparam int N = WIDTH / DIGIT;
  localparam int CW = N > 1 ? $clog2(N) : 1;
  if (WIDTH % DIGIT != 0) begin : g_bad_digit
    $error("sub_int32_serial: DIGIT must divide WIDTH");
  end
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t r_state;
  logic [WIDTH-1:0] r_a, r_b;
  logic r_c;
  logic [CW-1:0] r_cnt;
  logic [DIGIT:0] w_sum;
  logic [WIDTH+DIGIT-1:0] w_cat;
  logic [WIDTH-1:0] w_res;
  assign w_sum = {1'b0, r_a[DIGIT-1:0]} + {1'b0, r_b[DIGIT-1:0]} + {{DIGIT{1'b0}}, r_c};
  // new digit enters at the MSB end; after N beats the first digit sits at the LSB
  assign w_cat = {w_sum[DIGIT-1:0], result};
  assign w_res = w_cat[WIDTH+DIGIT-1:DIGIT];
`ifdef SUB_INT32_SERIAL_FLAGS_EN
  // on the last beat the operand MSBs are in the top bit of the low digit; B holds ~b
  logic w_a_msb, w_b_msb, w_ovf;
  assign w_a_msb = r_a[DIGIT-1];
  assign w_b_msb = ~r_b[DIGIT-1];
  assign w_ovf = (w_a_msb != w_b_msb) && (w_res[WIDTH-1] != w_a_msb);
`endif
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      in_ready <= 1'b0;
      out_valid <= 1'b0;
      result <= '0;
      borrow_out <= 1'b0;
      r_a <= '0;
      r_b <= '0;
      r_c <= 1'b0;
      r_cnt <= '0;
`ifdef SUB_INT32_SERIAL_FLAGS_EN
      overflow <= 1'b0;
      zero <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          in_ready <= 1'b1;
          if (in_valid && in_ready) begin
            r_a <= a;
            r_b <= ~b;
            r_c <= 1'b1;
            r_cnt <= '0;
            in_ready <= 1'b0;
            r_state <= RUN;
          end
        end
        RUN: begin
          r_a <= r_a >> DIGIT;
          r_b <= r_b >> DIGIT;
          r_c <= w_sum[DIGIT];
          result <= w_res;
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == CW'(N - 1)) begin
            r_state <= DONE;
            out_valid <= 1'b1;
            borrow_out <= ~w_sum[DIGIT];
`ifdef SUB_INT32_SERIAL_FLAGS_EN
            overflow <= w_ovf;
            zero <= (w_res == '0);
`endif
          end
        end
        DONE: begin
          if (out_ready) begin
            r_state <= IDLE;
            out_valid <= 1'b0;
            in_ready <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule
